dmem_responder: RTL and testbench

Data-memory responder for the pipelined core's MEM stage. It replaces the combinational data memory with a memory that uses a valid/ready request and response handshake and a fixed, parameterized access latency. It accepts one load or store at a time, holds the request for LATENCY cycles, then commits or reads the word and presents a response until the initiator takes it. The core's MEM stage is the initiator and stalls on req_ready_o and resp_valid_o.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store with a
// valid/ready request and response handshake and a fixed access latency.
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam bit DIRECT = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            lat_write;
  logic [31:0]     lat_addr;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;

  logic            accept;
  logic            wait_done;
  logic            do_access;
  logic            use_live;
  logic            acc_write;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_be;
  logic            acc_err;
  logic [IW-1:0]   acc_idx;
  logic            mem_we;

  logic [31:0]     mem [DEPTH_WORDS];

  assign req_ready_o  = (state_q == IDLE) && !rst_i;
  assign resp_valid_o = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);

  assign accept    = req_valid_i && req_ready_o;
  assign wait_done = (state_q == WAIT) && (cnt_q == CW'(1)) && !rst_i;
  assign do_access = (accept && DIRECT) || wait_done;

  // With a single-cycle latency the access happens on the acceptance edge,
  // before the request registers hold anything, so the live inputs are used.
  assign use_live  = (state_q == IDLE);
  assign acc_write = use_live ? req_write_i : lat_write;
  assign acc_addr  = use_live ? req_addr_i  : lat_addr;
  assign acc_wdata = use_live ? req_wdata_i : lat_wdata;
  assign acc_be    = use_live ? req_be_i    : lat_be;

  assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> 2) >= 32'(DEPTH_WORDS));
  assign acc_idx = acc_addr[IW+1:2];
  assign mem_we  = do_access && acc_write && !acc_err;

  // NOTE: every clocked process uses non-blocking assignments so all state
  // updates on an edge see the same pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults are assigned first so no path through the case leaves an
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CNT_LOAD;
          state_d = DIRECT ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture is qualified by accept, which is already low during reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lat_write <= req_write_i;
      lat_addr  <= req_addr_i;
      lat_wdata <= req_wdata_i;
      lat_be    <= req_be_i;
    end
  end

  // NOTE: the storage array has no reset; contents survive rst_i and only
  // enabled byte lanes of a committed, error-free store are written.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_we && acc_be[k]) begin
        mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else if (do_access) begin
      resp_err_o   <= acc_err;
      resp_rdata_o <= (acc_write || acc_err) ? '0 : mem[acc_idx];
    end else if ((state_q == RESP) && resp_ready_i) begin
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=3 instance under random
// backpressure and a LATENCY=1 instance with the response side always ready.
module tb_dmem_responder;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;
  localparam int WORDS = 128;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        a_resp_valid, a_resp_ready, a_err, a_busy;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic        b_resp_valid, b_err, b_busy;
  logic        b_resp_ready = 1'b1;

  dmem_responder #(.DEPTH_WORDS(WORDS), .LATENCY(LAT_A)) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_be_i(a_be),
    .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
    .resp_rdata_o(a_rdata), .resp_err_o(a_err), .busy_o(a_busy)
  );

  dmem_responder #(.DEPTH_WORDS(WORDS), .LATENCY(LAT_B)) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_be_i(b_be),
    .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
    .resp_rdata_o(b_rdata), .resp_err_o(b_err), .busy_o(b_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory contents, one image per instance.
  logic [31:0] mdl [2][WORDS];
  exp_t        q_a[$];
  exp_t        q_b[$];

  int          last_hs_a = -1;
  logic [31:0] last_rdata_a = '0;
  logic        last_err_a = 1'b0;
  int          b_prev_acc = -1;
  bit          hold_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Expected response of one access; stores update the image at acceptance,
  // which is safe because only one request is ever outstanding.
  function automatic exp_t model(input int d, input bit w, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    int   idx;
    e.data = '0;
    e.acc  = 0;
    e.err  = (addr % 4 != 0) || (addr / 4 >= WORDS);
    if (!e.err) begin
      idx = int'(addr / 4);
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (be[k]) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
      end else begin
        e.data = mdl[d][idx];
      end
    end
    return e;
  endfunction

  // Presents a request to instance A and returns just after its acceptance edge.
  task automatic issue_a(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input bit expect_resp);
    int   start;
    int   n;
    int   acc;
    bit   rdy;
    exp_t e;
    a_req_valid = 1'b1;
    a_req_write = w;
    a_addr      = addr;
    a_wdata     = wd;
    a_be        = be;
    start = cyc;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = a_req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    a_req_valid = 1'b0;
    acc = cyc;
    if (!rdy) begin
      fail_event("a_accept_timeout");
    end else begin
      if (expect_resp) begin
        e = model(0, w, addr, wd, be);
        e.acc = acc;
        q_a.push_back(e);
      end
      if (last_hs_a > start) check("a_accept_after_handshake", 32'(acc), 32'(last_hs_a + 1));
    end
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((q_a.size() != 0 || a_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_event("a_idle_timeout");
    @(posedge clk);
    #1;
  endtask

  // Instance B keeps req_valid high between requests to measure throughput.
  task automatic issue_b(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
    int   n;
    int   acc;
    bit   rdy;
    exp_t e;
    b_req_valid = 1'b1;
    b_req_write = w;
    b_addr      = addr;
    b_wdata     = wd;
    b_be        = be;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = b_req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    acc = cyc;
    if (!rdy) begin
      fail_event("b_accept_timeout");
    end else begin
      e = model(1, w, addr, wd, be);
      e.acc = acc;
      q_b.push_back(e);
      if (b_prev_acc >= 0) check("b_accept_spacing", 32'(acc - b_prev_acc), 32'd2);
      b_prev_acc = acc;
    end
  endtask

  // Backpressure source for instance A.
  initial begin
    a_resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      a_resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor A: response latency, payload, stability under backpressure.
  initial begin
    bit          prev_v = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        prev_err = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        prev_hold = 1'b0;
      end else begin
        check("a_busy_vs_ready", a_busy, !a_req_ready);
        if (a_resp_valid) begin
          check("a_ready_low_in_resp", a_req_ready, 1'b0);
          if (!prev_v) begin
            if (q_a.size() == 0) fail_event("a_unexpected_response");
            else check("a_latency", 32'(cyc - q_a[0].acc), 32'(LAT_A - 1));
          end else if (prev_hold) begin
            check("a_hold_rdata", a_rdata, prev_rdata);
            check("a_hold_err", a_err, prev_err);
          end
          if (a_resp_ready && q_a.size() != 0) begin
            e = q_a.pop_front();
            check("a_rdata", a_rdata, e.data);
            check("a_err", a_err, e.err);
            last_hs_a    = cyc + 1;
            last_rdata_a = a_rdata;
            last_err_a   = a_err;
          end
        end else begin
          check("a_idle_rdata", a_rdata, 32'd0);
          check("a_idle_err", a_err, 1'b0);
        end
        prev_v     = a_resp_valid;
        prev_hold  = a_resp_valid && !a_resp_ready;
        prev_rdata = a_rdata;
        prev_err   = a_err;
      end
    end
  end

  // Monitor B: zero-gap response and ready again right after the handshake.
  initial begin
    bit   hs_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) check("b_ready_after_handshake", b_req_ready, 1'b1);
        hs_prev = 1'b0;
        if (b_resp_valid) begin
          if (q_b.size() == 0) begin
            fail_event("b_unexpected_response");
          end else begin
            e = q_b.pop_front();
            check("b_latency", 32'(cyc - e.acc), 32'(LAT_B - 1));
            check("b_rdata", b_rdata, e.data);
            check("b_err", b_err, e.err);
          end
          hs_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          r;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_a", a_req_ready, 1'b0);
    check("reset_ready_b", b_req_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", a_resp_valid, 1'b0);
    check("reset_busy", a_busy, 1'b0);
    check("reset_ready_after", a_req_ready, 1'b1);
    @(posedge clk);
    #1;

    // Full-word store and read-back.
    issue_a(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1);
    issue_a(1'b0, 32'h10, 32'h0, 4'b0000, 1'b1);
    wait_idle_a();
    check("t1_load", last_rdata_a, 32'hDEADBEEF);

    // Single byte-lane store.
    issue_a(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 1'b1);
    issue_a(1'b0, 32'h10, 32'h0, 4'b0000, 1'b1);
    wait_idle_a();
    check("t2_load", last_rdata_a, 32'hDEADABEF);

    for (int i = 0; i < 16; i++)
      if (i != 4) issue_a(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1);
    wait_idle_a();

    // Response held for five cycles while a second request waits.
    hold_low = 1'b1;
    @(posedge clk);
    #1;
    issue_a(1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
    fork
      issue_a(1'b0, 32'hC, 32'h0, 4'h0, 1'b1);
      begin
        repeat (LAT_A + 4) @(posedge clk);
        hold_low = 1'b0;
      end
    join
    wait_idle_a();

    // Error cases; a misaligned store must not disturb the word.
    issue_a(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 1'b1);
    wait_idle_a();
    check("t4_misaligned_err", last_err_a, 1'b1);
    issue_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    wait_idle_a();
    check("t4_unchanged", last_rdata_a, 32'hDEADABEF);
    issue_a(1'b0, 32'h200, 32'h0, 4'h0, 1'b1);
    wait_idle_a();
    check("t4_range_err", last_err_a, 1'b1);
    check("t4_range_rdata", last_rdata_a, 32'h0);

    // Reset right after acceptance drops the store.
    issue_a(1'b1, 32'h20, 32'h00001234, 4'hF, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_busy_after_reset", a_busy, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    issue_a(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    wait_idle_a();

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (r == 1) addr = 32'h200 + 32'($urandom_range(0, 1000) * 4);
      else             addr = 32'($urandom_range(0, 15) * 4);
      issue_a(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle_a();

    // Back-to-back traffic on the single-cycle instance.
    for (int i = 0; i < 8; i++) issue_b(1'b1, 32'(i * 4), $urandom, 4'hF);
    for (int i = 0; i < 8; i++) issue_b(1'b0, 32'(i * 4), 32'h0, 4'h0);
    b_req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (q_b.size() != 0) fail_event("b_responses_missing");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
